// File: rtl/seq_mult_16.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_16
// Purpose  : Unsigned 16x16->32 shift-and-add multiplier controller. Drives an
//            external combinational prefix adder once per clock for 16
//            iterations. The 17-bit sum {cout, s} is shifted right into the
//            HI:LO accumulator/multiplier pair, so no carry is lost.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout
);

  // Iteration counter is sized for exactly 16 passes (0..15).
  localparam logic [4:0] C_LAST_ITER = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q,  m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [4:0]       cnt_q, cnt_d;

  logic             w_run;

  assign w_run = (state_q == S_RUN);

  // Adder operand drive: accumulator plus (multiplicand or zero) during RUN,
  // all-zero otherwise so the adder inputs are quiet between operations.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (w_run) begin
      add_a = hi_q;
      add_b = lo_q[0] ? m_q : '0;
    end
  end

  // Status and result outputs are pure decodes of registered state.
  always_comb begin
    busy    = w_run;
    done    = (state_q == S_DONE);
    product = {hi_q, lo_q};
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = mcand;
          hi_d    = '0;
          lo_d    = mplier;
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Shift the full 17-bit sum right by one across HI:LO; the bit
        // leaving HI becomes the next product bit at the top of LO, while
        // the consumed multiplier bit falls off the bottom of LO.
        hi_d  = {add_cout, add_s[WIDTH-1:1]};
        lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/seq_mult_16.md
# seq_mult_16

Unsigned 16×16→32 shift-and-add multiplier controller. It drives the team's external 16-bit prefix adder through a dedicated operand/result port pair and performs one add-and-shift per clock over 16 iterations. It sits directly upstream of the adder, generating A/B/Cin, and directly downstream of it, consuming S/Cout. It gives the datapath a multiply op without a combinational array multiplier.

## Interface
- WIDTH, 16, operand width; must equal the attached adder width (only 16 is supported).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mcand  in  16  multiplicand; latched when start is accepted.
- mplier  in  16  multiplier; latched when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse in DONE.
- product  out  32  result register; valid from DONE until the next accepted start.
- add_a  out  16  to adder A.
- add_b  out  16  to adder B.
- add_cin  out  1  to adder Cin; constant 0.
- add_s  in  16  from adder S.
- add_cout  in  1  from adder Cout.

## Operation
- Registers:
  - M[15:0]: latched multiplicand.
  - HI[15:0], LO[15:0]: accumulator and multiplier shift register; product = {HI, LO}.
  - cnt[4:0]: iteration count.
  - state: IDLE, RUN, DONE.
- IDLE:
  - start=1 → M←mcand, HI←0, LO←mplier, cnt←0, go to RUN.
  - start=0 → hold all registers.
- RUN, each cycle:
  - add_a = HI.
  - add_b = LO[0] ? M : 16'h0000.
  - add_cin = 0.
  - HI ← {add_cout, add_s[15:1]}.
  - LO ← {add_s[0], LO[15:1]}.
  - cnt ← cnt+1.
  - When cnt==15 at the edge (16th iteration), go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. Registers hold.
- Outside RUN, add_a and add_b are driven to 0.
- busy is decoded from state==RUN; done from state==DONE. Both are registered-state decodes, with no combinational path from start.
- start is ignored in RUN and DONE; the in-flight operation and its operands are unaffected.
- Arithmetic: the 17-bit sum {add_cout, add_s} is right-shifted into HI/LO each cycle, so no carry is lost. The final product is exact for all 2^32 input pairs.
- The adder is combinational and external. Its S/Cout must settle within the same cycle as add_a/add_b.

## Timing
- Reset value of every output: busy=0, done=0, product=0, add_a=0, add_b=0, add_cin=0. State is IDLE, all registers 0.
- Reset asserted mid-operation: abort immediately (asynchronous) and return to the reset values. No done pulse is produced for the aborted operation.
- Latency, with start sampled at edge E0:
  - busy=1 after E0 through edge E16.
  - done=1 in the cycle after E16; product is valid in that same cycle.
  - Back in IDLE after E17.
- Throughput: one operation per 18 cycles when start is held high continuously. Start is accepted at the first edge after done falls.
- product holds its value in IDLE until the next accepted start, which overwrites HI/LO on that edge.

## Test plan
- Reset, then start with mcand=3, mplier=5 → busy high for exactly 16 cycles, done pulses once, product=32'h0000000F in the done cycle and held afterward.
- mcand=16'hFFFF, mplier=16'hFFFF → product=32'hFFFE0001. Checks that every add_cout is captured.
- mcand=16'h1234, mplier=0, then mcand=0, mplier=16'hABCD → product=0 both times; add_b must stay 0 throughout RUN in the first case.
- Start with 16'h00FF × 16'h0101, then pulse start=1 with different operands during RUN and again during DONE → both pulses ignored; product=32'h0000FFFF.
- Assert rst at cycle 8 of RUN → all outputs 0 immediately, no done pulse. A fresh start with 7×9 then yields product=63.
- Hold start high across 3 ops with random operands → done pulses 18 cycles apart and each product matches a reference model. Include a 2000-vector random sweep against A*B.
